hs_cdc_pulse_sched: RTL
=======================

// Module: hs_cdc_pulse_sched
// PURPOSE
//  Source-domain scheduler sharing one CDC pulse-syncer lane between NUM_REQ requesters.
//  - Counts each requester's events in a saturating pending counter.
//  - Grants requesters round-robin and issues one single-cycle pulse per grant.
//  - Holds a stable tag naming the granted requester; the destination samples it on pulse arrival.
//  - Enforces a minimum inter-pulse gap and handles syncer overload recovery.
// PARAMETERS
//  NUM_REQ    4  number of requesters, 2-16
//  CNT_WIDTH  4  per-requester pending-counter width; saturates at 2**CNT_WIDTH-1
//  GAP_W      6  width of gap_cfg
//  MIN_GAP    6  hard floor on gap cycles; must be >= 2*SYNC_STAGE+2 of the driven syncer
// PORTS
//  clk             in   1                  source-domain clock
//  areset          in   1                  async reset, active high
//  en              in   1                  1 = new grants allowed
//  gap_cfg         in   GAP_W              requested gap cycles; effective gap = max(gap_cfg, MIN_GAP)
//  req_pulse       in   NUM_REQ            each cycle high = one event for that requester
//  req_pending     out  NUM_REQ            pending counter of requester i is non-zero
//  req_drop        out  NUM_REQ            sticky: an event was lost to saturation; cleared by drop_clr
//  drop_clr        in   1                  synchronous clear of req_drop and the stat counters
//  sync_pulse      out  1                  to syncer pulse_in; active high, one cycle long
//  sync_tag        out  $clog2(NUM_REQ)    id of last grant; held stable until the next grant
//  sync_overload   in   1                  from syncer fb_overload
//  sync_ovld_sclr  out  1                  to syncer overload_sclr; one-cycle pulse
//  busy            out  1                  FSM not IDLE, or any pending counter non-zero
//  stat_issue_cnt  out  16                 pulses issued, saturating
//  stat_drop_cnt   out  16                 events dropped, saturating
// BEHAVIOUR
//  Reset values: all outputs 0; counters 0; FSM IDLE; RR pointer at requester 0.
//  Counter update, per requester:
//   - +1 when req_pulse[i] is high; -1 when granted.
//   - Both in the same cycle: net no change.
//   - At max, with an increment and no grant: event dropped; req_drop[i] sets.
//  FSM states: IDLE, ISSUE, GAP, RECOVER.
//   - IDLE: if sync_overload=1, go to RECOVER (overload takes priority over grants).
//     Else if en=1 and any counter is non-zero: the RR arbiter grants the first non-zero
//     requester at or after ptr. Register the grant into sync_tag, decrement that counter,
//     set ptr = grant+1 (wraps to 0), go to ISSUE.
//   - ISSUE: sync_pulse=1 for exactly this cycle; load the gap counter with the effective gap;
//     go to GAP.
//   - GAP: decrement every cycle; at 1, go to IDLE. Effective gap = number of cycles spent in GAP.
//     If sync_overload=1 is seen in GAP, go to RECOVER immediately.
//   - RECOVER: sync_ovld_sclr=1 in the first cycle; wait 2*effective gap cycles; go to IDLE.
//     Pending events are retained and resume in RR order.
//  Latency: req_pulse high in cycle t with the block idle and the requester winning
//   -> sync_pulse high in cycle t+2.
//  Pulse spacing: consecutive sync_pulse rising edges are >= effective gap + 2 cycles apart.
//  en deassertion: an in-flight ISSUE/GAP completes; no new grant until en=1.
//   Counters keep accepting events while en=0.
//  gap_cfg: sampled only on IDLE->ISSUE; changes mid-gap take effect on the next grant.
//  Reset mid-operation: pending events are lost; no partial pulse is emitted.
//  Stat counters: saturate at 16'hFFFF; cleared by drop_clr.
// CONFIGURATION
//  HS_CDC_PULSE_SCHED_STATS_EN
//   - Defined: stat_issue_cnt and stat_drop_cnt are implemented.
//   - Undefined: both are tied to 16'h0 and no counter flops are inferred.
//   - req_drop is present in both builds.
// STRUCTURE
//  Package hs_cdc_pkg: typedef enum logic [1:0] pulse_sched_state_e {IDLE, ISSUE, GAP, RECOVER};
//   also localparam STAT_W = 16.
//  Sub-module hs_arb_rr: NUM_REQ-wide round-robin arbiter; req vector + pointer in,
//   one-hot and binary grant out; purely combinational.
//  Pending counters: generate loop over NUM_REQ.
//  Registers: built from hs_unit_dff / hs_unit_dff_ce.
// TESTING
//  T1 single event: req_pulse=4'b0010 for 1 cycle, gap_cfg=8
//     -> sync_pulse at t+2, sync_tag=1, busy low after 8 GAP cycles.
//  T2 RR fairness: all 4 requesters get 2 events at once
//     -> tags 0,1,2,3,0,1,2,3 with pulses 10 cycles apart (gap 8).
//  T3 saturation: 17 events on requester 2 with en=0 (CNT_WIDTH=4)
//     -> counter 15, req_drop[2]=1, stat_drop_cnt=2; en=1 -> exactly 15 pulses.
//  T4 gap floor: gap_cfg=0, MIN_GAP=6 -> pulse spacing 8 cycles.
//  T5 overload: sync_overload=1 in GAP cycle 3
//     -> sync_ovld_sclr 1 cycle, no pulse for 2*gap cycles, pending resumes.
//  T6 reset mid-GAP: areset during GAP with 3 pending
//     -> all outputs 0, no pulse after release until a new req_pulse.

Source files
------------

// File: rtl/hs_cdc_pkg.sv
// Shared types and constants for the CDC pulse scheduler.
package hs_cdc_pkg;

    localparam int unsigned STAT_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        GAP     = 2'd2,
        RECOVER = 2'd3
    } pulse_sched_state_e;

    // Saturating add used by the statistics counters.
    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                  input logic [STAT_W-1:0] b);
        logic [STAT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[STAT_W] ? '1 : s[STAT_W-1:0];
    endfunction

endpackage

// File: rtl/hs_arb_rr.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module hs_arb_rr #(
    parameter int unsigned  N  = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_oh_c_o,
    output logic [IW-1:0] gnt_idx_c_o,
    output logic          gnt_vld_c_o
);

    int unsigned idx;

    always_comb begin
        gnt_oh_c_o  = '0;
        gnt_idx_c_o = '0;
        gnt_vld_c_o = 1'b0;
        idx         = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!gnt_vld_c_o && req_i[IW'(idx)]) begin
                gnt_vld_c_o             = 1'b1;
                gnt_oh_c_o[IW'(idx)]    = 1'b1;
                gnt_idx_c_o             = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/hs_unit_dff.sv
// Plain register with asynchronous active-high reset to RST_VAL.
module hs_unit_dff #(
    parameter int unsigned   W       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_o <= RST_VAL;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/hs_unit_dff_ce.sv
// Register with load enable and asynchronous active-high reset to RST_VAL.
module hs_unit_dff_ce #(
    parameter int unsigned   W       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_o <= RST_VAL;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/hs_cdc_pulse_sched.sv
// Shares one CDC pulse-syncer lane between NUM_REQ requesters with RR grants and gap pacing.
// Optional statistics counters: define HS_CDC_PULSE_SCHED_STATS_EN.
module hs_cdc_pulse_sched
    import hs_cdc_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned CNT_WIDTH = 4,
    parameter int unsigned GAP_W     = 6,
    parameter int unsigned MIN_GAP   = 6
) (
    input  logic                       clk,
    input  logic                       areset,
    input  logic                       en,
    input  logic [GAP_W-1:0]           gap_cfg,
    input  logic [NUM_REQ-1:0]         req_pulse,
    output logic [NUM_REQ-1:0]         req_pending,
    output logic [NUM_REQ-1:0]         req_drop,
    input  logic                       drop_clr,
    output logic                       sync_pulse,
    output logic [$clog2(NUM_REQ)-1:0] sync_tag,
    input  logic                       sync_overload,
    output logic                       sync_ovld_sclr,
    output logic                       busy,
    output logic [STAT_W-1:0]          stat_issue_cnt,
    output logic [STAT_W-1:0]          stat_drop_cnt
);

    localparam int unsigned    TAG_W     = $clog2(NUM_REQ);
    localparam int unsigned    TMR_W     = GAP_W + 1;
    localparam logic [GAP_W-1:0] MIN_GAP_V = GAP_W'(MIN_GAP);

    pulse_sched_state_e state_q, state_d;
    logic [1:0]         state_raw_q;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [GAP_W-1:0]   eff_gap_q, eff_live;
    logic [TAG_W-1:0]   ptr_q, ptr_nxt, gnt_idx;
    logic [NUM_REQ-1:0] gnt_oh, cnt_nz, pending_d, drop_ev, drop_d;
    logic               gnt_vld, grant_fire, pulse_d, sclr_d, busy_d;

    logic [NUM_REQ-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

    assign eff_live = (gap_cfg < MIN_GAP_V) ? MIN_GAP_V : gap_cfg;
    assign ptr_nxt  = (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx + TAG_W'(1);

    hs_arb_rr #(.N(NUM_REQ)) u_arb (
        .req_i       (cnt_nz),
        .ptr_i       (ptr_q),
        .gnt_oh_c_o  (gnt_oh),
        .gnt_idx_c_o (gnt_idx),
        .gnt_vld_c_o (gnt_vld)
    );

    // Scheduler FSM: grant, pulse, pace, and recover from syncer overload.
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        grant_fire = 1'b0;
        pulse_d    = 1'b0;
        sclr_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync_overload) begin
                    state_d = RECOVER;
                    tmr_d   = {eff_live, 1'b0};
                    sclr_d  = 1'b1;
                end else if (en && gnt_vld) begin
                    state_d    = ISSUE;
                    grant_fire = 1'b1;
                    pulse_d    = 1'b1;
                end
            end
            ISSUE: begin
                state_d = GAP;
                tmr_d   = TMR_W'(eff_gap_q);
            end
            GAP: begin
                if (sync_overload) begin
                    state_d = RECOVER;
                    tmr_d   = {eff_gap_q, 1'b0};
                    sclr_d  = 1'b1;
                end else if (tmr_q <= TMR_W'(1)) begin
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            RECOVER: begin
                if (tmr_q <= TMR_W'(1)) begin
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_q = pulse_sched_state_e'(state_raw_q);
    assign busy_d  = (state_d != IDLE) || (|cnt_d);
    assign drop_d  = drop_clr ? '0 : (req_drop | drop_ev);

    // Pending counters: simultaneous event and grant cancel; a full counter drops the event.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        logic inc, dec, full;
        assign inc          = req_pulse[i];
        assign dec          = grant_fire & gnt_oh[i];
        assign full         = (cnt_q[i] == '1);
        assign drop_ev[i]   = inc & ~dec & full;
        assign cnt_nz[i]    = |cnt_q[i];
        assign pending_d[i] = |cnt_d[i];
        assign cnt_d[i]     = (inc & ~dec & ~full) ? cnt_q[i] + CNT_WIDTH'(1) :
                              (dec & ~inc)         ? cnt_q[i] - CNT_WIDTH'(1) :
                                                     cnt_q[i];

        hs_unit_dff #(.W(CNT_WIDTH)) u_cnt (
            .clk_i(clk), .rst_i(areset), .d_i(cnt_d[i]), .q_o(cnt_q[i]));
    end

    hs_unit_dff #(.W(2), .RST_VAL(IDLE)) u_state (
        .clk_i(clk), .rst_i(areset), .d_i(state_d), .q_o(state_raw_q));
    hs_unit_dff #(.W(TMR_W)) u_tmr (
        .clk_i(clk), .rst_i(areset), .d_i(tmr_d), .q_o(tmr_q));
    hs_unit_dff #(.W(1)) u_pulse (
        .clk_i(clk), .rst_i(areset), .d_i(pulse_d), .q_o(sync_pulse));
    hs_unit_dff #(.W(1)) u_sclr (
        .clk_i(clk), .rst_i(areset), .d_i(sclr_d), .q_o(sync_ovld_sclr));
    hs_unit_dff #(.W(1)) u_busy (
        .clk_i(clk), .rst_i(areset), .d_i(busy_d), .q_o(busy));
    hs_unit_dff #(.W(NUM_REQ)) u_pend (
        .clk_i(clk), .rst_i(areset), .d_i(pending_d), .q_o(req_pending));
    hs_unit_dff #(.W(NUM_REQ)) u_drop (
        .clk_i(clk), .rst_i(areset), .d_i(drop_d), .q_o(req_drop));

    // Tag, pointer and effective gap are captured only on a grant.
    hs_unit_dff_ce #(.W(TAG_W)) u_tag (
        .clk_i(clk), .rst_i(areset), .en_i(grant_fire), .d_i(gnt_idx), .q_o(sync_tag));
    hs_unit_dff_ce #(.W(TAG_W)) u_ptr (
        .clk_i(clk), .rst_i(areset), .en_i(grant_fire), .d_i(ptr_nxt), .q_o(ptr_q));
    hs_unit_dff_ce #(.W(GAP_W)) u_gap (
        .clk_i(clk), .rst_i(areset), .en_i(grant_fire), .d_i(eff_live), .q_o(eff_gap_q));

`ifdef HS_CDC_PULSE_SCHED_STATS_EN
    logic [STAT_W-1:0] drop_num, issue_d, dropc_d;

    always_comb begin
        drop_num = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            drop_num = drop_num + STAT_W'(drop_ev[i]);
        end
    end

    assign issue_d = drop_clr ? '0 : sat_add(stat_issue_cnt, STAT_W'(pulse_d));
    assign dropc_d = drop_clr ? '0 : sat_add(stat_drop_cnt, drop_num);

    hs_unit_dff #(.W(STAT_W)) u_stat_issue (
        .clk_i(clk), .rst_i(areset), .d_i(issue_d), .q_o(stat_issue_cnt));
    hs_unit_dff #(.W(STAT_W)) u_stat_drop (
        .clk_i(clk), .rst_i(areset), .d_i(dropc_d), .q_o(stat_drop_cnt));
`else
    assign stat_issue_cnt = '0;
    assign stat_drop_cnt  = '0;
`endif

endmodule
